// File: rtl/div_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_rr_pkg (package)
// Description : Shared types and helpers for the round-robin divider
//               scheduler: FSM state encoding, default geometry and
//               pointer/count widths, and the round-robin winner search.
// Revision    : 1.0  initial release
// ============================================================================
package div_rr_pkg;

    localparam int c_DEF_N   = 4;
    localparam int c_DEF_W   = 4;
    localparam int c_PTR_W   = $clog2(c_DEF_N);
    localparam int c_CNT_W   = $clog2(c_DEF_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // First set bit of req[n-1:0] searching ptr, ptr+1, ... with wrap mod n.
    // The loop has a fixed bound so it unrolls to a plain priority mux.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        int  idx;
        int  win;
        bit  found;
        win   = 0;
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : div_rr_sched_if
// Description : Client-side bus of the shared divider scheduler.
//   req[N], dividend[N*W], divisor[N*W]  : client -> scheduler
//   gnt[N], done[N], quot[W], rem[W],
//   busy, dz                             : scheduler -> client
//   master = client side, slave = scheduler side.
// Revision    : 1.0  initial release
// ============================================================================
interface div_rr_sched_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] dividend;
    logic [N*W-1:0] divisor;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           busy;
    logic           dz;

    modport master (
        output req, dividend, divisor,
        input  gnt, done, quot, rem, busy, dz
    );

    modport slave (
        input  req, dividend, divisor,
        output gnt, done, quot, rem, busy, dz
    );
endinterface
`default_nettype wire

// File: rtl/div_rr_sched_core.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_core
// Description : Unsigned restoring divider, one iteration per clock.
//   clk, rst (async, active-low)
//   start            : latch dividend/divisor and begin W iterations
//   dividend, divisor: operands (sampled on start)
//   done             : high in the cycle whose closing edge runs the last
//                      iteration (quot/rem are final after that edge)
//   quot, rem        : working quotient / partial remainder
// Revision    : 1.0  initial release
// ============================================================================
module div_iter_core
    import div_rr_pkg::*;
#(
    parameter int W = c_DEF_W
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          start,
    input  wire  [W-1:0] dividend,
    input  wire  [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    localparam int c_CW = (W > 1) ? $clog2(W) : 1;

    // W+1-bit partial remainder keeps divisors with the MSB set correct.
    logic [W:0]      r_prem;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_dvs;
    logic [c_CW-1:0] r_cnt;
    logic            r_run;

    logic [W+1:0]    w_shift;
    logic [W+1:0]    w_trial;
    logic            w_last;

    // One extra guard bit so the trial subtraction's MSB is its sign.
    assign w_shift = {r_prem, r_q[W-1]};
    assign w_trial = w_shift - {2'b00, r_dvs};
    assign w_last  = r_run && (r_cnt == c_CW'(W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prem <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (start) begin
            r_prem <= '0;
            r_q    <= dividend;
            r_dvs  <= divisor;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_prem <= w_trial[W+1] ? w_shift[W:0] : w_trial[W:0];
            r_q    <= {r_q[W-2:0], ~w_trial[W+1]};
            if (w_last) begin
                r_cnt <= '0;
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done = w_last;
    assign quot = r_q;
    assign rem  = r_prem[W-1:0];

endmodule
`default_nettype wire

// File: rtl/div_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : div_rr_sched
// Description : Round-robin scheduler sharing one sequential restoring
//               divider among N requesters.
//   clk, rst (async, active-low)
//   bus.slave : req/dividend/divisor in; gnt/done (one-hot pulses),
//               quot/rem (held until next done), busy, dz out.
//   Optional  : DIV_RR_DZ_DETECT_EN - divisor 0 bypasses the iterations and
//               reports dz=1 with done; otherwise dz is tied 0.
// Revision    : 1.0  initial release
// ============================================================================
module div_rr_sched
    import div_rr_pkg::*;
#(
    parameter int N = c_DEF_N,
    parameter int W = c_DEF_W
) (
    input  wire           clk,
    input  wire           rst,
    div_rr_sched_if.slave bus
);
    localparam int c_PW = (N > 1) ? $clog2(N) : 1;

    state_t          r_state;
    logic [c_PW-1:0] r_ptr;
    logic [c_PW-1:0] r_owner;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    r_done;
    logic [W-1:0]    r_quot;
    logic [W-1:0]    r_rem;

    int              w_win_i;
    logic [c_PW-1:0] w_win;
    logic [N-1:0]    w_win_oh;
    logic [N-1:0]    w_own_oh;
    logic [W-1:0]    w_sel_dvd;
    logic [W-1:0]    w_sel_dvs;
    logic            w_any_req;
    logic            w_skip_run;
    logic            w_core_start;
    logic            w_core_done;
    logic [W-1:0]    w_core_quot;
    logic [W-1:0]    w_core_rem;

    always_comb begin
        w_win_i   = rr_pick(32'(bus.req), int'(r_ptr), N);
        w_win     = c_PW'(w_win_i);
        w_sel_dvd = bus.dividend[w_win_i*W +: W];
        w_sel_dvs = bus.divisor[w_win_i*W +: W];
    end

    assign w_any_req = |bus.req;
    assign w_win_oh  = N'(1) << w_win;
    assign w_own_oh  = N'(1) << r_owner;

`ifdef DIV_RR_DZ_DETECT_EN
    logic         r_dz_path;
    logic         r_dz;
    logic [W-1:0] r_zdvd;
    assign w_skip_run = (w_sel_dvs == '0);
`else
    assign w_skip_run = 1'b0;
`endif

    // The core only starts for operations that actually iterate.
    assign w_core_start = (r_state == S_IDLE) && w_any_req && !w_skip_run;

    div_iter_core #(.W(W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (w_core_start),
        .dividend (w_sel_dvd),
        .divisor  (w_sel_dvs),
        .done     (w_core_done),
        .quot     (w_core_quot),
        .rem      (w_core_rem)
    );

    // gnt/done are registered one-cycle pulses; done lands in the first
    // IDLE cycle, so the next accept can happen on the edge that ends it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
`ifdef DIV_RR_DZ_DETECT_EN
            r_dz_path <= 1'b0;
            r_dz      <= 1'b0;
            r_zdvd    <= '0;
`endif
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
`ifdef DIV_RR_DZ_DETECT_EN
            r_dz   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_win;
                        r_gnt   <= w_win_oh;
`ifdef DIV_RR_DZ_DETECT_EN
                        r_dz_path <= w_skip_run;
                        r_zdvd    <= w_sel_dvd;
                        r_state   <= w_skip_run ? S_DONE : S_RUN;
`else
                        r_state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (w_core_done) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done <= w_own_oh;
`ifdef DIV_RR_DZ_DETECT_EN
                    if (r_dz_path) begin
                        r_quot <= '1;
                        r_rem  <= r_zdvd;
                        r_dz   <= 1'b1;
                    end else begin
                        r_quot <= w_core_quot;
                        r_rem  <= w_core_rem;
                    end
`else
                    r_quot <= w_core_quot;
                    r_rem  <= w_core_rem;
`endif
                    r_ptr   <= (r_owner == c_PW'(N - 1)) ? '0 : r_owner + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.quot = r_quot;
    assign bus.rem  = r_rem;
    assign bus.busy = (r_state != S_IDLE);
`ifdef DIV_RR_DZ_DETECT_EN
    assign bus.dz   = r_dz;
`else
    assign bus.dz   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_rr_sched
// Description : Self-checking bench for div_rr_sched (N=4, W=4): client
//               driver, reference model of arbitration and arithmetic,
//               scoreboard queue and output monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_rr_sched;
    localparam int N = 4;
    localparam int W = 4;
`ifdef DIV_RR_DZ_DETECT_EN
    localparam bit c_DZ = 1'b1;
`else
    localparam bit c_DZ = 1'b0;
`endif

    typedef struct {
        int           port;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    div_rr_sched_if #(.N(N), .W(W)) bus ();

    div_rr_sched #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t           sb[$];
    int             errors = 0;
    int             checks = 0;
    int             cyc = 0;
    bit             model_idle = 1'b1;
    int             mptr = 0;
    bit             snap_idle = 1'b1;
    logic [N-1:0]   snap_req = '0;
    logic [N*W-1:0] snap_dvd = '0;
    logic [N*W-1:0] snap_dvs = '0;
    bit             want [N];
    bit             cont [N];
    logic [W-1:0]   wx [N];
    logic [W-1:0]   wy [N];
    int             grants [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Winner = first requester at or after the pointer, wrapping around.
    function automatic int rr_model(input logic [N-1:0] r, input int p);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic exp_t ref_op(input int port, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input int now);
        exp_t e;
        e.port = port;
        if (y == 0) begin
            e.q   = '1;
            e.r   = x;
            e.dz  = c_DZ;
            e.due = c_DZ ? now + 1 : now + W + 1;
        end else begin
            e.q   = x / y;
            e.r   = x % y;
            e.dz  = 1'b0;
            e.due = now + W + 1;
        end
        return e;
    endfunction

    // Monitor: predicts gnt from the previous cycle's idle/req view,
    // pops the scoreboard when a done is due, checks busy every cycle.
    initial begin : mon
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        int           w;
        exp_t         e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                eg = '0;
                if (snap_idle && snap_req != '0) begin
                    w     = rr_model(snap_req, mptr);
                    eg[w] = 1'b1;
                    sb.push_back(ref_op(w, snap_dvd[w*W +: W], snap_dvs[w*W +: W], cyc));
                    model_idle = 1'b0;
                    grants[w]++;
                end
                if (eg != '0 || bus.gnt != '0) check("gnt", 32'(bus.gnt), 32'(eg));
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    ed = '0;
                    ed[e.port] = 1'b1;
                    check("done", 32'(bus.done), 32'(ed));
                    check("quot", 32'(bus.quot), 32'(e.q));
                    check("rem",  32'(bus.rem),  32'(e.r));
                    check("dz",   32'(bus.dz),   32'(e.dz));
                    model_idle = 1'b1;
                    mptr = (e.port + 1) % N;
                end else if (bus.done != '0) begin
                    check("done_unexpected", 32'(bus.done), 32'd0);
                end
                check("busy", 32'(bus.busy), 32'(!model_idle));
            end
            snap_idle = model_idle;
            snap_req  = bus.req;
            snap_dvd  = bus.dividend;
            snap_dvs  = bus.divisor;
        end
    end

    // Client driver: raise req with operands when wanted, drop it on gnt.
    initial begin : drv
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && bus.gnt[i]) begin
                    bus.req[i] = 1'b0;
                    want[i]    = 1'b0;
                    if (cont[i]) begin
                        wx[i]   = W'($urandom_range(0, 15));
                        wy[i]   = W'($urandom_range(1, 15));
                        want[i] = 1'b1;
                    end
                end else if (!bus.req[i] && want[i]) begin
                    bus.dividend[i*W +: W] = wx[i];
                    bus.divisor[i*W +: W]  = wy[i];
                    bus.req[i]             = 1'b1;
                end
            end
        end
    end

    task automatic ask(input int p, input logic [W-1:0] x, input logic [W-1:0] y);
        wx[p]   = x;
        wy[p]   = y;
        want[p] = 1'b1;
    endtask

    function automatic bit any_want();
        for (int i = 0; i < N; i++) if (want[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((any_want() || bus.req != '0 || sb.size() != 0 || !model_idle) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: still active after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic assert_rst();
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        model_idle = 1'b1;
        mptr = 0;
        #1;
        check("rst_gnt",  32'(bus.gnt),  32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_quot", 32'(bus.quot), 32'd0);
        check("rst_rem",  32'(bus.rem),  32'd0);
        check("rst_dz",   32'(bus.dz),   32'd0);
    endtask

    task automatic release_rst();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin : main
        int g2;
        int gp;
        int n;
        int p;
        bus.req      = '0;
        bus.dividend = '0;
        bus.divisor  = '0;
        for (int i = 0; i < N; i++) begin
            want[i]   = 1'b0;
            cont[i]   = 1'b0;
            grants[i] = 0;
            wx[i]     = '0;
            wy[i]     = '0;
        end

        // Reset state, then a single request on port 1.
        assert_rst();
        release_rst();
        ask(1, 4'd13, 4'd3);
        wait_idle(50);
        check("port1_grants", 32'(grants[1]), 32'd1);

        // All four together right after reset: boundary operands.
        assert_rst();
        release_rst();
        ask(0, 4'd14, 4'd15);
        ask(1, 4'd15, 4'd1);
        ask(2, 4'd15, 4'd8);
        ask(3, 4'd9,  4'd0);
        wait_idle(100);

        // Port 0 re-requests continuously alongside port 2.
        g2 = grants[2];
        cont[0] = 1'b1;
        cont[2] = 1'b1;
        ask(0, 4'd7, 4'd2);
        ask(2, 4'd12, 4'd5);
        repeat (60) @(negedge clk);
        cont[0] = 1'b0;
        cont[2] = 1'b0;
        wait_idle(100);
        check("port2_not_starved", 32'((grants[2] - g2) >= 4), 32'd1);

        // Randomized traffic, divisor 0 included.
        repeat (40) begin
            p = $urandom_range(0, N - 1);
            if (!want[p] && !bus.req[p])
                ask(p, W'($urandom_range(0, 15)),
                    ($urandom_range(0, 4) == 0) ? W'(0) : W'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle(600);

        // Reset during RUN (count=2): operation discarded, pointer back to 0.
        ask(2, 4'd11, 4'd2);
        ask(3, 4'd7, 4'd3);
        n = 0;
        while (bus.gnt == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("gnt_seen_before_rst", 32'(bus.gnt != '0), 32'd1);
        gp = (bus.gnt[3]) ? 3 : 2;
        repeat (2) @(negedge clk);
        assert_rst();
        want[gp] = 1'b1;
        release_rst();
        n = 0;
        while (bus.gnt == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("first_gnt_after_rst", 32'(bus.gnt), 32'b0100);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
